decode_issue_ctrl: RTL and testbench
====================================

# decode_issue_ctrl

Decode-stage issue controller for the RV32IM pipeline. It holds one fetched instruction in a single-entry instruction register and decodes opcode/funct3 into the 4-bit immediate-select code that drives the immediate generator. It releases the instruction to EX with a valid/ready handshake, inserts a one-cycle bubble on a load-use hazard, and drops its contents on a branch/jump flush. It sits between the IF/ID boundary and the ID/EX pipeline register.

## Interface
- CNT_W, 16, width of the saturating stall counter

- CLK  in  1  pipeline clock, all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- IF_VALID  in  1  fetch presents an instruction
- IF_INST  in  32  fetched instruction
- IF_PC  in  32  PC of IF_INST
- IF_READY  out  1  controller accepts IF_INST this cycle
- FLUSH  in  1  taken branch/jump from EX; kill held instruction
- EX_READY  in  1  ID/EX register advances this cycle
- ID_VALID  out  1  ID_INST/ID_PC/IMM_SELECT valid for issue (0 = bubble)
- ID_INST  out  32  held instruction
- ID_PC  out  32  held PC
- IMM_SELECT  out  4  immediate-select code for the immediate generator
- ID_ILLEGAL  out  1  held opcode not in RV32IM
- STALL_COUNT  out  CNT_W  number of load-use bubbles inserted, saturating

## Operation
- States: EMPTY (V=0), FULL (V=1, no hazard), STALL (V=1, hazard). A held instruction is in FULL or STALL, and the state is derived each cycle.
- hazard = V & LAST_LOAD & (LAST_RD != 0) & ((rs1_used & rs1==LAST_RD) | (rs2_used & rs2==LAST_RD)).
- rs1_used: every opcode except LUI, AUIPC and JAL. rs2_used: R-type (incl. M), STORE, BRANCH.
- ID_VALID = V & ~hazard. issue = ID_VALID & EX_READY.
- IF_READY = ~FLUSH & (~V | issue). Accept when IF_VALID & IF_READY: load IR/PC and set V. Accepting and issuing in the same cycle is allowed.
- EMPTY→FULL on accept. FULL→EMPTY on issue without accept. FULL→FULL on issue with accept, or on no issue.
- FULL→STALL when hazard is computed true. STALL lasts exactly one EX_READY cycle, then becomes FULL.
- LAST_LOAD/LAST_RD update only when EX_READY=1: LAST_LOAD <= issue & (opcode==LOAD), LAST_RD <= IR[11:7]. A bubble issued with EX_READY therefore clears LAST_LOAD. When EX_READY=0 both hold.
- FLUSH: clears V next edge. An IF input in the same cycle is not accepted. LAST_LOAD/LAST_RD are unaffected.
- IMM_SELECT[2:0], decoded from IR:
  - LUI/AUIPC 000
  - JAL 001
  - LOAD, JALR, OP-IMM non-shift 010
  - BRANCH 011
  - STORE 100
  - OP-IMM shifts (funct3 001/101) 101
  - R-type and illegal 000, don't-care downstream
- IMM_SELECT[3]=1 only for SLTIU (OP-IMM funct3 011) and BLTU/BGEU (BRANCH funct3 110/111), else 0.
- ID_ILLEGAL=1 when V and opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP}. An illegal instruction still issues normally.
- STALL_COUNT increments by 1 on each cycle with hazard & EX_READY. It holds at all-ones.

## Timing
- Reset (async assert, sync release): V=0, LAST_LOAD=0, LAST_RD=0, IR=0, PC=0, STALL_COUNT=0.
- Reset outputs: ID_VALID=0, IF_READY=1, ID_INST=0, ID_PC=0, IMM_SELECT=0000, ID_ILLEGAL=0.
- Latency: instruction accepted at edge N is presented with ID_VALID at cycle N+1. With no hazard and EX_READY=1, throughput is 1 instr/cycle.
- Load-use: dependent instruction behind a load is presented one cycle late. Exactly one bubble (ID_VALID=0) is inserted.
- IF_READY, ID_VALID and IMM_SELECT are combinational from registered state plus FLUSH/EX_READY. No combinational path from IF_* to ID_*.
- FLUSH and a hazard in the same cycle: FLUSH wins, V=0 next. STALL_COUNT still counts if EX_READY=1.
- Reset asserted mid-stall: all state clears immediately and no partial issue occurs.

## Test plan
- Reset, then stream ADDI x1,x0,5 / LUI x2,0x12345 / JAL x0,8 / SW x1,4(x2) with EX_READY=1 → one issue per cycle, IMM_SELECT 0010,0000,0001,0100, STALL_COUNT=0.
- LW x5,0(x1) then ADD x6,x5,x7 → ADD held one cycle with ID_VALID=0 and IF_READY=0, issues next cycle, STALL_COUNT=1. Same sequence with LW x0 → no bubble.
- SLTIU, BLTU, SLLI x3,x3,4, BEQ → IMM_SELECT 1010, 1011, 0101, 0011.
- EX_READY=0 for 3 cycles with instruction held → ID_INST/ID_PC stable, IF_READY=0, LAST_LOAD unchanged. After release the held instruction issues once.
- FLUSH with V=1 and IF_VALID=1 → IF_READY=0, ID_VALID=0 next cycle. Next accepted instruction issues normally.
- Force 2^CNT_W+3 load-use bubbles (CNT_W=4 build) → STALL_COUNT saturates at 0xF. Opcode 7'b1111111 → ID_ILLEGAL=1, IMM_SELECT=0000.

Source files
------------

// File: rtl/decode_issue_ctrl.sv
// ---------------------------------------------------------------------------
// decode_issue_ctrl
// Decode-stage issue controller for the RV32IM pipeline. Holds one fetched
// instruction, decodes its immediate-select code, releases it to EX with a
// valid/ready handshake, inserts a single bubble on a load-use hazard and
// drops the held instruction on a branch/jump flush.
//
// Ports
//   clk          pipeline clock, all state on the rising edge
//   reset        asynchronous reset, active low
//   if_valid     fetch presents an instruction
//   if_inst      fetched instruction
//   if_pc        PC of if_inst
//   if_ready     controller accepts if_inst this cycle (combinational)
//   flush        taken branch/jump from EX, kills the held instruction
//   ex_ready     ID/EX register advances this cycle
//   id_valid     id_inst/id_pc/imm_select valid for issue (combinational)
//   id_inst      held instruction
//   id_pc        held PC
//   imm_select   immediate-select code for the immediate generator
//   id_illegal   held opcode is not an RV32IM opcode
//   stall_count  saturating count of load-use bubbles inserted
// ---------------------------------------------------------------------------
module decode_issue_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [31:0]      if_inst,
    input  logic [31:0]      if_pc,
    output logic             if_ready,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             id_valid,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc,
    output logic [3:0]       imm_select,
    output logic             id_illegal,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned OPC_W     = 7;
    localparam int unsigned F3_W      = 3;
    localparam int unsigned SEL_W     = 3;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    // Immediate-generator format codes (low three bits of imm_select)
    localparam logic [SEL_W-1:0] SEL_U     = 3'b000;
    localparam logic [SEL_W-1:0] SEL_J     = 3'b001;
    localparam logic [SEL_W-1:0] SEL_I     = 3'b010;
    localparam logic [SEL_W-1:0] SEL_B     = 3'b011;
    localparam logic [SEL_W-1:0] SEL_S     = 3'b100;
    localparam logic [SEL_W-1:0] SEL_SHAMT = 3'b101;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        STALL = 2'b10
    } state_t;

    // Registered state
    logic                 v_q;
    logic [XLEN-1:0]      ir_q;
    logic [XLEN-1:0]      pc_q;
    logic                 last_load_q;
    logic [REG_W-1:0]     last_rd_q;
    logic [CNT_W-1:0]     stall_cnt_q;

    // Combinational decode / control
    logic [OPC_W-1:0]     opcode_c;
    logic [F3_W-1:0]      funct3_c;
    logic [REG_W-1:0]     rs1_c;
    logic [REG_W-1:0]     rs2_c;
    logic [SEL_W-1:0]     imm_sel_c;
    logic                 imm_unsg_c;
    logic                 legal_c;
    logic                 rs1_used_c;
    logic                 rs2_used_c;
    logic                 hazard_c;
    state_t               state_c;
    logic                 issue_c;
    logic                 accept_c;
    logic                 v_d;

    assign opcode_c = ir_q[6:0];
    assign funct3_c = ir_q[14:12];
    assign rs1_c    = ir_q[19:15];
    assign rs2_c    = ir_q[24:20];

    // Opcode/funct3 decode of the held instruction
    always_comb begin
        imm_sel_c  = SEL_U;
        imm_unsg_c = 1'b0;
        legal_c    = 1'b1;
        rs1_used_c = 1'b1;
        rs2_used_c = 1'b0;
        case (opcode_c)
            OPC_LUI, OPC_AUIPC: begin
                rs1_used_c = 1'b0;
            end
            OPC_JAL: begin
                imm_sel_c  = SEL_J;
                rs1_used_c = 1'b0;
            end
            OPC_LOAD, OPC_JALR: begin
                imm_sel_c = SEL_I;
            end
            OPC_OPIMM: begin
                // SLLI/SRLI/SRAI take a shamt field instead of a full I-immediate
                if (funct3_c == 3'b001 || funct3_c == 3'b101) begin
                    imm_sel_c = SEL_SHAMT;
                end else begin
                    imm_sel_c = SEL_I;
                end
                imm_unsg_c = (funct3_c == 3'b011);
            end
            OPC_BRANCH: begin
                imm_sel_c  = SEL_B;
                rs2_used_c = 1'b1;
                imm_unsg_c = (funct3_c[2:1] == 2'b11);
            end
            OPC_STORE: begin
                imm_sel_c  = SEL_S;
                rs2_used_c = 1'b1;
            end
            OPC_OP: begin
                rs2_used_c = 1'b1;
            end
            default: begin
                legal_c = 1'b0;
            end
        endcase
    end

    // Load-use hazard against the instruction that just left for EX
    always_comb begin
        hazard_c = 1'b0;
        if (v_q && last_load_q && (last_rd_q != '0)) begin
            hazard_c = (rs1_used_c && (rs1_c == last_rd_q)) ||
                       (rs2_used_c && (rs2_c == last_rd_q));
        end
    end

    // Occupancy state is derived every cycle from V and the hazard
    always_comb begin
        state_c = EMPTY;
        if (v_q) begin
            state_c = hazard_c ? STALL : FULL;
        end
    end

    // Handshake and next occupancy
    always_comb begin
        id_valid = 1'b0;
        if_ready = 1'b0;
        issue_c  = 1'b0;
        accept_c = 1'b0;
        v_d      = v_q;
        case (state_c)
            EMPTY: begin
                if_ready = ~flush;
                accept_c = if_valid & ~flush;
                v_d      = accept_c;
            end
            FULL: begin
                id_valid = 1'b1;
                issue_c  = ex_ready;
                if_ready = ~flush & ex_ready;
                accept_c = if_valid & ~flush & ex_ready;
                v_d      = accept_c | ~issue_c;
            end
            STALL: begin
                // Bubble cycle: the held instruction stays put
                v_d = 1'b1;
            end
            default: begin
                v_d = 1'b0;
            end
        endcase
        if (flush) begin
            v_d = 1'b0;
        end
    end

    // Occupancy and instruction register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q  <= 1'b0;
            ir_q <= '0;
            pc_q <= '0;
        end else begin
            v_q <= v_d;
            if (accept_c) begin
                ir_q <= if_inst;
                pc_q <= if_pc;
            end
        end
    end

    // Tracking of the last instruction handed to EX; frozen while EX stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_load_q <= 1'b0;
            last_rd_q   <= '0;
        end else if (ex_ready) begin
            last_load_q <= issue_c & (opcode_c == OPC_LOAD);
            last_rd_q   <= ir_q[11:7];
        end
    end

    // Saturating bubble counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (hazard_c && ex_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign id_inst     = ir_q;
    assign id_pc       = pc_q;
    assign imm_select  = {imm_unsg_c, imm_sel_c};
    assign id_illegal  = v_q & ~legal_c;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the decode stage.
module tb_decode_issue_ctrl;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_valid;
    logic [31:0]   if_inst;
    logic [31:0]   if_pc;
    logic          if_ready;
    logic          flush;
    logic          ex_ready;
    logic          id_valid;
    logic [31:0]   id_inst;
    logic [31:0]   id_pc;
    logic [3:0]    imm_select;
    logic          id_illegal;
    logic [CW-1:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic          m_v;
    logic [31:0]   m_ir;
    logic [31:0]   m_pc;
    logic          m_ll;
    logic [4:0]    m_lrd;
    logic [CW-1:0] m_cnt;

    decode_issue_ctrl #(.CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_ready    (if_ready),
        .flush       (flush),
        .ex_ready    (ex_ready),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .imm_select  (imm_select),
        .id_illegal  (id_illegal),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction encoders
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {7'b0, rs2, rs1, f3, rd, op};
    endfunction

    // Reference decode
    function automatic logic ref_legal(input logic [31:0] inst);
        case (inst[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ref_imm(input logic [31:0] inst);
        logic [2:0] f3;
        f3 = inst[14:12];
        case (inst[6:0])
            7'h6F:        return 4'b0001;
            7'h03, 7'h67: return 4'b0010;
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) return 4'b0101;
                if (f3 == 3'd3)               return 4'b1010;
                return 4'b0010;
            end
            7'h63:        return (f3 >= 3'd6) ? 4'b1011 : 4'b0011;
            7'h23:        return 4'b0100;
            default:      return 4'b0000;
        endcase
    endfunction

    function automatic logic m_hazard();
        logic [6:0] op;
        logic       r1u;
        logic       r2u;
        op  = m_ir[6:0];
        r1u = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        r2u = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        return m_v && m_ll && (m_lrd != 5'd0) &&
               ((r1u && m_ir[19:15] == m_lrd) || (r2u && m_ir[24:20] == m_lrd));
    endfunction

    task automatic m_reset();
        m_v   = 1'b0;
        m_ir  = '0;
        m_pc  = '0;
        m_ll  = 1'b0;
        m_lrd = '0;
        m_cnt = '0;
    endtask

    // Apply inputs and let combinational outputs settle
    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic fl, input logic er);
        if_valid = v;
        if_inst  = inst;
        if_pc    = pc;
        flush    = fl;
        ex_ready = er;
        #1;
    endtask

    // Advance one clock and the model alongside it
    task automatic tick();
        logic hz, idv, iss, ifr, acc;
        hz  = m_hazard();
        idv = m_v & ~hz;
        iss = idv & ex_ready;
        ifr = ~flush & (~m_v | iss);
        acc = if_valid & ifr;
        @(posedge clk);
        if (ex_ready) begin
            m_ll  = iss & (m_ir[6:0] == 7'h03);
            m_lrd = m_ir[11:7];
        end
        if (hz && ex_ready && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        if (acc) begin
            m_ir = if_inst;
            m_pc = if_pc;
        end
        if (flush)    m_v = 1'b0;
        else if (acc) m_v = 1'b1;
        else if (iss) m_v = 1'b0;
        #1;
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        m_reset();
        @(posedge clk);
        #1;
        n_tests++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1 || id_inst !== 32'h0 || id_pc !== 32'h0 ||
            imm_select !== 4'b0000 || id_illegal !== 1'b0 || stall_count !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b rdy=%b inst=%h pc=%h imm=%b ill=%b cnt=%0d, expected 0 1 0 0 0000 0 0",
                     id_valid, if_ready, id_inst, id_pc, imm_select, id_illegal, stall_count);
        end
        reset = 1'b1;
        #1;
    endtask

    task automatic test_stream();
        logic [31:0] insts [4];
        logic [3:0]  imms  [4];
        insts[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
        insts[1] = {20'h12345, 5'd2, 7'h37};
        insts[2] = 32'h0080006F;
        insts[3] = {7'd0, 5'd1, 5'd2, 3'b010, 5'd4, 7'h23};
        imms = '{4'b0010, 4'b0000, 4'b0001, 4'b0100};
        drive(1'b1, insts[0], 32'h100, 1'b0, 1'b1);
        n_tests++;
        if (if_ready !== 1'b1 || id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_first: rdy=%b v=%b, expected 1 0", if_ready, id_valid);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b1, insts[i+1], 32'h100 + 32'(4*(i+1)), 1'b0, 1'b1);
            else       drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            n_tests++;
            if (id_valid !== 1'b1 || if_ready !== 1'b1 || id_inst !== insts[i] ||
                id_pc !== 32'h100 + 32'(4*i) || imm_select !== imms[i]) begin
                n_fail++;
                $display("FAIL stream_%0d: v=%b rdy=%b inst=%h pc=%h imm=%b, expected 1 1 %h %h %b",
                         i, id_valid, if_ready, id_inst, id_pc, imm_select,
                         insts[i], 32'h100 + 32'(4*i), imms[i]);
            end
            tick();
        end
        n_tests++;
        if (id_valid !== 1'b0 || stall_count !== '0) begin
            n_fail++;
            $display("FAIL stream_end: v=%b cnt=%0d, expected 0 0", id_valid, stall_count);
        end
    endtask

    task automatic test_load_use();
        logic [31:0]   lw, add, nop;
        logic [CW-1:0] base;
        base = m_cnt;
        lw   = enc_i(12'd0, 5'd1, 3'd2, 5'd5, 7'h03);
        add  = enc_r(5'd7, 5'd5, 3'd0, 5'd6, 7'h33);
        nop  = enc_i(12'd0, 5'd0, 3'd0, 5'd0, 7'h13);
        drive(1'b1, lw, 32'h200, 1'b0, 1'b1);
        tick();
        drive(1'b1, add, 32'h204, 1'b0, 1'b1);
        tick();
        drive(1'b1, nop, 32'h208, 1'b0, 1'b1);
        n_tests++;
        if (id_valid !== 1'b0 || if_ready !== 1'b0 || id_inst !== add) begin
            n_fail++;
            $display("FAIL load_use_bubble: v=%b rdy=%b inst=%h, expected 0 0 %h", id_valid, if_ready, id_inst, add);
        end
        tick();
        n_tests++;
        if (id_valid !== 1'b1 || id_inst !== add || stall_count !== CW'(base + 1)) begin
            n_fail++;
            $display("FAIL load_use_issue: v=%b inst=%h cnt=%0d, expected 1 %h %0d",
                     id_valid, id_inst, stall_count, add, CW'(base + 1));
        end
        drain();
        // Load into x0 never creates a dependency
        base = m_cnt;
        drive(1'b1, enc_i(12'd0, 5'd1, 3'd2, 5'd0, 7'h03), 32'h210, 1'b0, 1'b1);
        tick();
        drive(1'b1, enc_r(5'd7, 5'd0, 3'd0, 5'd6, 7'h33), 32'h214, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        n_tests++;
        if (id_valid !== 1'b1 || stall_count !== base) begin
            n_fail++;
            $display("FAIL load_x0_no_bubble: v=%b cnt=%0d, expected 1 %0d", id_valid, stall_count, base);
        end
        drain();
    endtask

    task automatic test_imm_select();
        logic [31:0] insts [4];
        logic [3:0]  imms  [4];
        insts[0] = enc_i(12'd1, 5'd2, 3'd3, 5'd1, 7'h13);
        insts[1] = enc_r(5'd2, 5'd1, 3'd6, 5'd0, 7'h63);
        insts[2] = enc_i(12'd4, 5'd3, 3'd1, 5'd3, 7'h13);
        insts[3] = enc_r(5'd2, 5'd1, 3'd0, 5'd8, 7'h63);
        imms = '{4'b1010, 4'b1011, 4'b0101, 4'b0011};
        drive(1'b1, insts[0], 32'h300, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1'b1, insts[i+1], 32'h300 + 32'(4*(i+1)), 1'b0, 1'b1);
            else       drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            n_tests++;
            if (id_valid !== 1'b1 || imm_select !== imms[i] || id_illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL imm_sel_%0d: v=%b imm=%b ill=%b, expected 1 %b 0",
                         i, id_valid, imm_select, id_illegal, imms[i]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_ex_stall();
        logic [31:0]   addi, lw, add;
        logic [CW-1:0] base;
        addi = enc_i(12'd7, 5'd1, 3'd0, 5'd9, 7'h13);
        drive(1'b1, addi, 32'h400, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h00000013, 32'h404, 1'b0, 1'b0);
            n_tests++;
            if (id_valid !== 1'b1 || if_ready !== 1'b0 || id_inst !== addi || id_pc !== 32'h400) begin
                n_fail++;
                $display("FAIL ex_hold_%0d: v=%b rdy=%b inst=%h pc=%h, expected 1 0 %h 00000400",
                         k, id_valid, if_ready, id_inst, id_pc, addi);
            end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        n_tests++;
        if (id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ex_release_once: v=%b, expected 0", id_valid);
        end
        drain();
        // Stalled EX keeps the load-use tracking frozen
        base = m_cnt;
        lw   = enc_i(12'd0, 5'd1, 3'd2, 5'd5, 7'h03);
        add  = enc_r(5'd5, 5'd2, 3'd0, 5'd6, 7'h33);
        drive(1'b1, lw, 32'h410, 1'b0, 1'b1);
        tick();
        drive(1'b1, add, 32'h414, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h00000013, 32'h418, 1'b0, 1'b0);
            n_tests++;
            if (id_valid !== 1'b0 || if_ready !== 1'b0 || id_pc !== 32'h414 || stall_count !== base) begin
                n_fail++;
                $display("FAIL ex_stall_hazard_%0d: v=%b rdy=%b pc=%h cnt=%0d, expected 0 0 00000414 %0d",
                         k, id_valid, if_ready, id_pc, stall_count, base);
            end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        n_tests++;
        if (id_valid !== 1'b1 || id_inst !== add || stall_count !== CW'(base + 1)) begin
            n_fail++;
            $display("FAIL ex_stall_issue: v=%b inst=%h cnt=%0d, expected 1 %h %0d",
                     id_valid, id_inst, stall_count, add, CW'(base + 1));
        end
        drain();
    endtask

    task automatic test_flush();
        logic [31:0]   nxt;
        logic [CW-1:0] base;
        drive(1'b1, enc_i(12'd1, 5'd1, 3'd0, 5'd2, 7'h13), 32'h500, 1'b0, 1'b1);
        tick();
        drive(1'b1, enc_i(12'd2, 5'd1, 3'd0, 5'd3, 7'h13), 32'h504, 1'b1, 1'b0);
        n_tests++;
        if (if_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: rdy=%b, expected 0", if_ready);
        end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        n_tests++;
        if (id_valid !== 1'b0 || id_pc !== 32'h500) begin
            n_fail++;
            $display("FAIL flush_kill: v=%b pc=%h, expected 0 00000500", id_valid, id_pc);
        end
        nxt = enc_i(12'd3, 5'd1, 3'd0, 5'd4, 7'h13);
        drive(1'b1, nxt, 32'h510, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        n_tests++;
        if (id_valid !== 1'b1 || id_inst !== nxt || id_pc !== 32'h510) begin
            n_fail++;
            $display("FAIL flush_next: v=%b inst=%h pc=%h, expected 1 %h 00000510", id_valid, id_inst, id_pc, nxt);
        end
        drain();
        // Flush wins over a hazard, the bubble is still counted
        base = m_cnt;
        drive(1'b1, enc_i(12'd0, 5'd1, 3'd2, 5'd5, 7'h03), 32'h520, 1'b0, 1'b1);
        tick();
        drive(1'b1, enc_r(5'd7, 5'd5, 3'd0, 5'd6, 7'h33), 32'h524, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h00000013, 32'h528, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        n_tests++;
        if (id_valid !== 1'b0 || stall_count !== CW'(base + 1)) begin
            n_fail++;
            $display("FAIL flush_hazard: v=%b cnt=%0d, expected 0 %0d", id_valid, stall_count, CW'(base + 1));
        end
        drain();
    endtask

    task automatic test_illegal();
        drive(1'b1, 32'h1234507F, 32'h600, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        n_tests++;
        if (id_illegal !== 1'b1 || imm_select !== 4'b0000 || id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_flag: ill=%b imm=%b v=%b, expected 1 0000 1", id_illegal, imm_select, id_valid);
        end
        tick();
        n_tests++;
        if (id_illegal !== 1'b0 || id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_issued: ill=%b v=%b, expected 0 0", id_illegal, id_valid);
        end
        drain();
    endtask

    task automatic test_random();
        logic [6:0]  ops [10];
        logic [6:0]  op;
        logic [31:0] inst;
        logic        hz, e_idv, e_ifr, e_ill;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
        for (int c = 0; c < 1500; c++) begin
            op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 3) == 0) op = 7'h03;
            inst = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    3'($urandom), 5'($urandom_range(0, 3)), op};
            drive($urandom_range(0, 3) != 0, inst, $urandom, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 9) < 7);
            hz    = m_hazard();
            e_idv = m_v & ~hz;
            e_ifr = ~flush & (~m_v | (e_idv & ex_ready));
            e_ill = m_v & ~ref_legal(m_ir);
            n_tests++;
            if (id_valid !== e_idv || if_ready !== e_ifr || id_inst !== m_ir || id_pc !== m_pc ||
                id_illegal !== e_ill || stall_count !== m_cnt ||
                (m_v && imm_select !== ref_imm(m_ir))) begin
                n_fail++;
                $display("FAIL random_%0d: v=%b rdy=%b inst=%h pc=%h ill=%b cnt=%0d imm=%b, expected %b %b %h %h %b %0d %b",
                         c, id_valid, if_ready, id_inst, id_pc, id_illegal, stall_count, imm_select,
                         e_idv, e_ifr, m_ir, m_pc, e_ill, m_cnt, ref_imm(m_ir));
            end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, enc_i(12'd0, 5'd1, 3'd2, 5'd5, 7'h03), 32'h700, 1'b0, 1'b1);
        tick();
        drive(1'b1, enc_r(5'd7, 5'd5, 3'd0, 5'd6, 7'h33), 32'h704, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h00000013, 32'h708, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        m_reset();
        n_tests++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1 || id_inst !== 32'h0 || id_pc !== 32'h0 ||
            stall_count !== '0 || imm_select !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_stall: v=%b rdy=%b inst=%h pc=%h cnt=%0d imm=%b, expected 0 1 0 0 0 0000",
                     id_valid, if_ready, id_inst, id_pc, stall_count, imm_select);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (id_valid !== 1'b0 || id_inst !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hold: v=%b inst=%h, expected 0 0", id_valid, id_inst);
        end
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_saturation();
        logic [CW-1:0] exp_cnt;
        for (int k = 0; k < (1 << CW) + 3; k++) begin
            drive(1'b1, enc_i(12'd0, 5'd1, 3'd2, 5'd5, 7'h03), 32'h800, 1'b0, 1'b1);
            tick();
            drive(1'b1, enc_r(5'd7, 5'd5, 3'd0, 5'd6, 7'h33), 32'h804, 1'b0, 1'b1);
            tick();
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            tick();
            tick();
            exp_cnt = (k + 1 >= (1 << CW) - 1) ? '1 : CW'(k + 1);
            n_tests++;
            if (stall_count !== exp_cnt) begin
                n_fail++;
                $display("FAIL saturate_%0d: cnt=%0d, expected %0d", k, stall_count, exp_cnt);
            end
        end
        n_tests++;
        if (stall_count !== 4'hF) begin
            n_fail++;
            $display("FAIL saturate_final: cnt=%h, expected f", stall_count);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_load_use();
        test_imm_select();
        test_ex_stall();
        test_flush();
        test_illegal();
        test_random();
        test_reset_mid_stall();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
